mem_bus_ctrl: RTL and testbench

Memory bus controller sitting directly downstream of the DLX control state machine. It accepts that machine's REQ/MR/MW request together with the address and store data, and runs one handshaked read or write on the memory-side bus. It reports completion back through BUSY and holds the read word for the IR/C-register paths. Each transaction is bounded by a timeout so a dead slave cannot hang the processor.

---
 rtl/mem_bus_ctrl_if.sv | 28 ++
 rtl/mem_bus_ctrl.sv | 113 +++++++++++
 tb/tb_mem_bus_ctrl.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_ctrl_if.sv
// Bundles the control-FSM request side and the memory-side bus of mem_bus_ctrl.
// The slave modport is the controller's view; the master modport drives it.
interface mem_bus_ctrl_if;
  logic        req;
  logic        mr;
  logic        mw;
  logic [31:0] addr;
  logic [31:0] din;
  logic        busy;
  logic [31:0] dout;
  logic        err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport slave (
    input  req, mr, mw, addr, din, mem_rdata, mem_ack,
    output busy, dout, err, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req, mr, mw, addr, din, mem_rdata, mem_ack,
    input  busy, dout, err, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_bus_ctrl.sv
// Single-transaction memory bus controller behind the DLX control FSM:
// IDLE -> ACCESS (handshake, bounded by TIMEOUT) -> DONE -> IDLE.
module mem_bus_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  mem_bus_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic             r_err_flag;
  logic             r_mem_req;
  logic             r_mem_we;
  logic [31:0]      r_mem_addr;
  logic [31:0]      r_mem_wdata;
  logic [31:0]      r_dout;

  logic             w_accept;
  logic             w_illegal;
  logic             w_timeout;
  logic             w_rd_ack;
  logic             w_busy;

  // ACK wins over timeout when both land on the last allowed ACCESS cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_illegal   = 1'b0;
    w_timeout   = 1'b0;
    w_rd_ack    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.req) begin
          if (bus.mr == bus.mw) begin
            w_illegal   = 1'b1;
            w_state_nxt = S_DONE;
          end else begin
            w_accept    = 1'b1;
            w_state_nxt = S_ACCESS;
          end
        end
      end
      S_ACCESS: begin
        if (bus.mem_ack) begin
          w_rd_ack    = ~r_mem_we;
          w_state_nxt = S_DONE;
        end else if (r_cnt == CNT_LAST) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Combinational so the requester stalls in its very first request cycle.
  assign w_busy = (r_state == S_ACCESS) | ((r_state == S_IDLE) & bus.req);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt       <= '0;
      r_err_flag  <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_dout      <= '0;
    end else begin
      r_mem_req <= (w_state_nxt == S_ACCESS);
      if (w_accept) begin
        r_cnt       <= '0;
        r_err_flag  <= 1'b0;
        r_mem_we    <= bus.mw;
        r_mem_addr  <= bus.addr;
        r_mem_wdata <= bus.din;
      end else begin
        if (r_state == S_ACCESS) r_cnt <= r_cnt + 1'b1;
        if (w_illegal | w_timeout) r_err_flag <= 1'b1;
      end
      if (w_rd_ack) r_dout <= bus.mem_rdata;
    end
  end

  assign bus.busy      = w_busy;
  assign bus.dout      = r_dout;
  assign bus.err       = (r_state == S_DONE) & r_err_flag;
  assign bus.mem_req   = r_mem_req;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Self-checking bench for mem_bus_ctrl: directed vector table, hand sequences,
// and randomized transactions scored against a transaction-level model.
module tb_mem_bus_ctrl;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_bus_ctrl_if bus();

  mem_bus_ctrl #(.TIMEOUT(TO), .CNT_W(3)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        mr;
    logic        mw;
    logic [31:0] addr;
    logic [31:0] din;
    int          ack_at;   // ACCESS cycle (1-based) carrying ACK; 0 = never
    logic [31:0] rdata;
    int          exp_busy;
    int          exp_mreq;
    logic        exp_err;
    logic [31:0] exp_dout;
  } vec_t;

  vec_t vecs[8];
  logic [31:0] model_dout;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Runs one request as the control FSM would (REQ held through DONE) and
  // measures what the bus and the requester saw.
  task automatic run_txn(input logic mr, input logic mw, input logic [31:0] addr,
                         input logic [31:0] din, input int ack_at, input logic [31:0] rdata,
                         output int busy_n, output int mreq_n, output logic err_seen,
                         output logic [31:0] dout_done, output int stab_bad,
                         output logic we_seen, output logic post_ok);
    bit done;
    busy_n = 0; mreq_n = 0; err_seen = 1'b0; dout_done = '0;
    stab_bad = 0; we_seen = 1'b0; post_ok = 1'b1; done = 1'b0;
    @(negedge clk);
    bus.req = 1'b1; bus.mr = mr; bus.mw = mw; bus.addr = addr; bus.din = din;
    bus.mem_ack = 1'b0; bus.mem_rdata = $urandom;
    #1 if (bus.busy) busy_n++;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      bus.addr = $urandom; bus.din = $urandom;
      if (bus.mem_req) begin
        mreq_n++;
        if (bus.mem_addr !== addr || bus.mem_wdata !== din || bus.mem_we !== mw) stab_bad++;
        we_seen = bus.mem_we;
        bus.mem_ack   = (mreq_n == ack_at);
        bus.mem_rdata = (mreq_n == ack_at) ? rdata : $urandom;
        #1 if (bus.busy) busy_n++;
      end else begin
        bus.mem_ack = 1'b0;
        #1;
        if (bus.busy) busy_n++;
        else begin
          err_seen  = bus.err;
          dout_done = bus.dout;
          done      = 1'b1;
        end
      end
    end
    if (!done) post_ok = 1'b0;
    @(negedge clk);
    bus.req = 1'b0; bus.mr = 1'b0; bus.mw = 1'b0; bus.mem_ack = 1'b0;
    #1 if (bus.busy !== 1'b0 || bus.mem_req !== 1'b0 || bus.err !== 1'b0) post_ok = 1'b0;
  endtask

  task automatic check_txn(input string tag, input logic mr, input logic mw,
                           input logic [31:0] addr, input logic [31:0] din, input int ack_at,
                           input logic [31:0] rdata, input int exp_busy, input int exp_mreq,
                           input logic exp_err, input logic [31:0] exp_dout);
    int b, m, s; logic e, w, p; logic [31:0] d;
    run_txn(mr, mw, addr, din, ack_at, rdata, b, m, e, d, s, w, p);
    chk({tag, ".busy_cycles"}, b, exp_busy);
    chk({tag, ".mreq_cycles"}, m, exp_mreq);
    chk({tag, ".err"}, {31'd0, e}, {31'd0, exp_err});
    chk({tag, ".dout"}, d, exp_dout);
    chk({tag, ".bus_stable"}, s, 0);
    chk({tag, ".post_idle"}, {31'd0, p}, 32'd1);
    if (exp_mreq > 0) chk({tag, ".mem_we"}, {31'd0, w}, {31'd0, mw});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{mr:1, mw:0, addr:32'h100, din:32'h0, ack_at:1, rdata:32'hDEADBEEF,
                exp_busy:2, exp_mreq:1, exp_err:0, exp_dout:32'hDEADBEEF};
    vecs[1] = '{mr:0, mw:1, addr:32'h40, din:32'h12345678, ack_at:4, rdata:32'hFFFF0000,
                exp_busy:5, exp_mreq:4, exp_err:0, exp_dout:32'hDEADBEEF};
    vecs[2] = '{mr:1, mw:0, addr:32'h80, din:32'h0, ack_at:0, rdata:32'h0,
                exp_busy:5, exp_mreq:4, exp_err:1, exp_dout:32'hDEADBEEF};
    vecs[3] = '{mr:1, mw:1, addr:32'h44, din:32'h9, ack_at:1, rdata:32'h1111,
                exp_busy:1, exp_mreq:0, exp_err:1, exp_dout:32'hDEADBEEF};
    vecs[4] = '{mr:0, mw:0, addr:32'h48, din:32'h9, ack_at:1, rdata:32'h2222,
                exp_busy:1, exp_mreq:0, exp_err:1, exp_dout:32'hDEADBEEF};
    vecs[5] = '{mr:1, mw:0, addr:32'h200, din:32'h0, ack_at:2, rdata:32'hA5A50001,
                exp_busy:3, exp_mreq:2, exp_err:0, exp_dout:32'hA5A50001};
    vecs[6] = '{mr:0, mw:1, addr:32'h204, din:32'hCAFE0001, ack_at:1, rdata:32'h3333,
                exp_busy:2, exp_mreq:1, exp_err:0, exp_dout:32'hA5A50001};
    vecs[7] = '{mr:1, mw:0, addr:32'h208, din:32'h0, ack_at:5, rdata:32'h4444,
                exp_busy:5, exp_mreq:4, exp_err:1, exp_dout:32'hA5A50001};

    rst_n = 1'b0;
    bus.req = 1'b0; bus.mr = 1'b0; bus.mw = 1'b0; bus.addr = '0; bus.din = '0;
    bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    #1;
    chk("reset.mem_req", {31'd0, bus.mem_req}, 32'd0);
    chk("reset.err", {31'd0, bus.err}, 32'd0);
    chk("reset.dout", bus.dout, 32'd0);
    chk("reset.mem_addr", bus.mem_addr, 32'd0);
    chk("reset.busy_idle", {31'd0, bus.busy}, 32'd0);
    bus.req = 1'b1;
    #1 chk("reset.busy_follows_req", {31'd0, bus.busy}, 32'd1);
    bus.req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++)
      check_txn($sformatf("vec%0d", i), vecs[i].mr, vecs[i].mw, vecs[i].addr, vecs[i].din,
                vecs[i].ack_at, vecs[i].rdata, vecs[i].exp_busy, vecs[i].exp_mreq,
                vecs[i].exp_err, vecs[i].exp_dout);

    // ACK while idle must not touch DOUT or start a bus cycle.
    @(negedge clk);
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h0BAD0BAD;
    @(negedge clk);
    #1;
    chk("idle_ack.dout", bus.dout, 32'hA5A50001);
    chk("idle_ack.mem_req", {31'd0, bus.mem_req}, 32'd0);
    chk("idle_ack.busy", {31'd0, bus.busy}, 32'd0);
    bus.mem_ack = 1'b0;

    // Instruction fetch followed by a load, REQ held through each DONE.
    check_txn("fetch", 1'b1, 1'b0, 32'h0, 32'h0, 1, 32'h8C220004, 2, 1, 1'b0, 32'h8C220004);
    check_txn("load", 1'b1, 1'b0, 32'h4, 32'h0, 2, 32'h55, 3, 2, 1'b0, 32'h55);
    chk("load.mem_addr_held", bus.mem_addr, 32'h4);

    // Reset lands on the second wait cycle of a read.
    @(negedge clk);
    bus.req = 1'b1; bus.mr = 1'b1; bus.mw = 1'b0; bus.addr = 32'h300; bus.mem_ack = 1'b0;
    @(negedge clk);
    #1 chk("rst_mid.access1", {31'd0, bus.mem_req}, 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid.mem_req", {31'd0, bus.mem_req}, 32'd0);
    chk("rst_mid.dout", bus.dout, 32'd0);
    chk("rst_mid.mem_addr", bus.mem_addr, 32'd0);
    chk("rst_mid.busy_req", {31'd0, bus.busy}, 32'd1);
    bus.req = 1'b0; bus.mr = 1'b0;
    #1 chk("rst_mid.busy_noreq", {31'd0, bus.busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_mid.after_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_mid.after_mreq", {31'd0, bus.mem_req}, 32'd0);
    model_dout = 32'd0;

    // Random transactions against a transaction-level model.
    for (int n = 0; n < 60; n++) begin
      logic mr, mw, legal, ok;
      int op, ack_at, eb, em;
      logic [31:0] a, d, rd;
      op = $urandom_range(0, 9);
      mr = (op == 0) ? 1'b1 : (op == 1) ? 1'b0 : op[0];
      mw = (op == 0) ? 1'b1 : (op == 1) ? 1'b0 : ~op[0];
      a = $urandom; d = $urandom; rd = $urandom;
      ack_at = $urandom_range(0, TO + 2);
      legal = (mr != mw);
      ok = legal && ack_at >= 1 && ack_at <= TO;
      eb = !legal ? 1 : ok ? ack_at + 1 : TO + 1;
      em = !legal ? 0 : ok ? ack_at : TO;
      if (ok && mr) model_dout = rd;
      check_txn($sformatf("rnd%0d", n), mr, mw, a, d, ack_at, rd, eb, em, !ok, model_dout);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
